kb_decode: RTL and testbench

KB_DECODE -- requirements
Module: kb_decode

---
 rtl/kb_pkg.sv | 41 ++++
 rtl/kb_fifo.sv | 71 +++++++
 rtl/kb_decode.sv | 140 ++++++++++++++
 tb/tb_kb_decode.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/kb_pkg.sv
// Shared definitions for the PS/2 Set-2 scan-code decoder.
package kb_pkg;

  // Scan-code bytes the prefix FSM reacts to
  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_E1 = 8'hE1;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_AA = 8'hAA;
  localparam logic [7:0] SC_00 = 8'h00;
  localparam logic [7:0] SC_FF = 8'hFF;
  localparam logic [7:0] SC_12 = 8'h12;
  localparam logic [7:0] SC_59 = 8'h59;
  localparam logic [7:0] SC_14 = 8'h14;
  localparam logic [7:0] SC_11 = 8'h11;

  // Event word layout: {ext, brk, code[7:0]}
  localparam int unsigned EVT_W    = 10;
  localparam int unsigned EVT_EXT  = 9;
  localparam int unsigned EVT_BRK  = 8;
  localparam int unsigned EVT_CODE = 0;

  // Bytes following E1 that belong to the Pause sequence
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_PAUSE   = 3'd4
  } kb_state_e;

  function automatic logic is_abort(input logic [7:0] b);
    return (b == SC_00) || (b == SC_FF);
  endfunction

  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == SC_12) || (b == SC_59);
  endfunction

endpackage

// File: rtl/kb_fifo.sv
// First-word fall-through event FIFO with sticky overflow flag.
module kb_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 10
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_wr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_rd,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_overflow;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_pop   = i_rd && !w_empty;
  // A full FIFO still accepts a write when the same cycle frees a slot
  assign w_push  = i_wr && (!w_full || w_pop);

  assign o_rdata    = r_mem[r_rd_ptr];
  assign o_valid    = !w_empty;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

  // Pointers, occupancy and overflow flag; clear outranks push/pop
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (i_clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (i_wr && !w_push) r_overflow <= 1'b1;
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge i_clk) begin
    if (w_push && !i_clr) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/kb_decode.sv
// PS/2 Set-2 prefix decoder: turns scan bytes into {ext, brk, code} events,
// tracks modifier keys and queues events in a FIFO.
module kb_decode
  import kb_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ready_i,
  input  logic [7:0]             code_i,
  input  logic                   rd_i,
  input  logic                   clr_i,
  output logic [EVT_W-1:0]       evt_o,
  output logic                   evt_valid_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o,
  output logic [2:0]             mods_o
);

  kb_state_e  r_state;
  kb_state_e  w_state_nxt;
  logic [2:0] r_skip;
  logic [2:0] w_skip_nxt;
  logic [2:0] r_mods;
  logic       w_emit;
  logic       w_ext;
  logic       w_brk;
  logic [7:0] w_code;
  logic [EVT_W-1:0] w_evt;

  // Prefix FSM state and Pause skip counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_skip  <= '0;
    end else if (clr_i) begin
      r_state <= ST_IDLE;
      r_skip  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_skip  <= w_skip_nxt;
    end
  end

  // Next-state decode and event generation for each accepted byte
  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip;
    w_emit      = 1'b0;
    w_ext       = 1'b0;
    w_brk       = 1'b0;
    w_code      = code_i;
    if (ready_i) begin
      case (r_state)
        ST_IDLE: begin
          if (code_i == SC_E0) begin
            w_state_nxt = ST_EXT;
          end else if (code_i == SC_F0) begin
            w_state_nxt = ST_BRK;
          end else if (code_i == SC_E1) begin
            w_state_nxt = ST_PAUSE;
            w_skip_nxt  = PAUSE_SKIP;
          end else if (!is_abort(code_i) && code_i != SC_AA) begin
            w_emit = 1'b1;
          end
        end
        ST_EXT: begin
          w_state_nxt = ST_IDLE;
          if (code_i == SC_F0 && !is_abort(code_i)) begin
            w_state_nxt = ST_EXT_BRK;
          end else if (!is_abort(code_i) && !is_fake_shift(code_i)) begin
            w_emit = 1'b1;
            w_ext  = 1'b1;
          end
        end
        ST_BRK: begin
          w_state_nxt = ST_IDLE;
          if (!is_abort(code_i)) begin
            w_emit = 1'b1;
            w_brk  = 1'b1;
          end
        end
        ST_EXT_BRK: begin
          w_state_nxt = ST_IDLE;
          if (!is_abort(code_i) && !is_fake_shift(code_i)) begin
            w_emit = 1'b1;
            w_ext  = 1'b1;
            w_brk  = 1'b1;
          end
        end
        ST_PAUSE: begin
          w_skip_nxt = r_skip - 1'b1;
          if (r_skip <= 3'd1) begin
            w_skip_nxt  = '0;
            w_state_nxt = ST_IDLE;
            w_emit      = 1'b1;
            w_ext       = 1'b1;
            w_code      = SC_E1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_evt = {w_ext, w_brk, w_code};

  // Held-modifier tracking on every emitted event, stored or dropped
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mods <= '0;
    end else if (clr_i) begin
      r_mods <= '0;
    end else if (w_emit) begin
      if (!w_ext && is_fake_shift(w_code)) r_mods[0] <= !w_brk;
      if (w_code == SC_14)                 r_mods[1] <= !w_brk;
      if (w_code == SC_11)                 r_mods[2] <= !w_brk;
    end
  end

  assign mods_o = r_mods;

  kb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_clr      (clr_i),
    .i_wr       (w_emit),
    .i_wdata    (w_evt),
    .i_rd       (rd_i),
    .o_rdata    (evt_o),
    .o_valid    (evt_valid_o),
    .o_count    (count_o),
    .o_overflow (overflow_o)
  );

endmodule

// File: tb/tb_kb_decode.sv
// Directed self-checking bench for kb_decode (DEPTH=8).
module tb_kb_decode;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] code = '0;
  logic       rd = 1'b0;
  logic       clr = 1'b0;
  logic [9:0] evt;
  logic       evt_valid;
  logic [3:0] count;
  logic       overflow;
  logic [2:0] mods;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  kb_decode #(.DEPTH(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .ready_i     (ready),
    .code_i      (code),
    .rd_i        (rd),
    .clr_i       (clr),
    .evt_o       (evt),
    .evt_valid_o (evt_valid),
    .count_o     (count),
    .overflow_o  (overflow),
    .mods_o      (mods)
  );

  always #5 clk = ~clk;

  // One clock of stimulus, applied on a falling edge, released on the next
  task automatic cyc(input logic r, input logic [7:0] b, input logic p, input logic c);
    @(negedge clk);
    ready = r; code = b; rd = p; clr = c;
    @(negedge clk);
    ready = 1'b0; rd = 1'b0; clr = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic clear();
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", evt_valid); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    n_checks++; if (mods !== 3'b000) begin n_fail++; $display("FAIL reset_mods: got %b want 000", mods); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_make();
    @(negedge clk);
    ready = 1'b1; code = 8'h1C;
    #1;
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL make_pre_valid: got %b want 0", evt_valid); end
    @(negedge clk);
    ready = 1'b0;
    n_checks++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL make_valid: got %b want 1", evt_valid); end
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL make_count: got %0d want 1", count); end
    n_checks++; if (evt !== 10'h01C) begin n_fail++; $display("FAIL make_evt: got %h want 01c", evt); end
    pop();
    n_checks++; if (evt_valid !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL make_pop: got valid=%b count=%0d want 0/0", evt_valid, count); end
  endtask

  task automatic test_ext_break();
    send(8'hE0); send(8'hF0);
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL extbrk_prefix: got count %0d want 0", count); end
    send(8'h74);
    n_checks++; if (count !== 4'd1 || evt !== 10'h374) begin n_fail++; $display("FAIL extbrk_evt: got count %0d evt %h want 1/374", count, evt); end
    pop();
    send(8'hE0); send(8'h12);
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL fake_shift: got count %0d want 0", count); end
    send(8'h00); send(8'hFF); send(8'hAA);
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL idle_discard: got count %0d want 0", count); end
    send(8'hF0); send(8'hFF); send(8'h1C);
    n_checks++; if (count !== 4'd1 || evt !== 10'h01C) begin n_fail++; $display("FAIL brk_abort: got count %0d evt %h want 1/01c", count, evt); end
    pop();
    send(8'hE0); send(8'h75);
    n_checks++; if (count !== 4'd1 || evt !== 10'h275) begin n_fail++; $display("FAIL ext_make: got count %0d evt %h want 1/275", count, evt); end
    pop();
    send(8'hF0); send(8'h75);
    n_checks++; if (count !== 4'd1 || evt !== 10'h175) begin n_fail++; $display("FAIL brk_make: got count %0d evt %h want 1/175", count, evt); end
    pop();
  endtask

  task automatic test_pause();
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 7; i++) send(seq[i]);
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL pause_early: got count %0d want 0", count); end
    send(seq[7]);
    n_checks++; if (count !== 4'd1 || evt !== 10'h2E1) begin n_fail++; $display("FAIL pause_evt: got count %0d evt %h want 1/2e1", count, evt); end
    pop();
    send(8'h1C);
    n_checks++; if (evt !== 10'h01C) begin n_fail++; $display("FAIL pause_after: got evt %h want 01c", evt); end
    pop();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) send(8'h15 + 8'(i));
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL ovf_count: got %0d want 8", count); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (evt !== 10'h015 + 10'(i)) begin n_fail++; $display("FAIL ovf_order%0d: got %h want %h", i, evt, 10'h015 + 10'(i)); end
      pop();
    end
    n_checks++; if (count !== 4'd0 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_drain: got count %0d ovf %b want 0/1", count, overflow); end
    clear();
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b want 0", overflow); end
  endtask

  task automatic test_full_wr_rd();
    for (int i = 0; i < 8; i++) send(8'h20 + 8'(i));
    cyc(1'b1, 8'h30, 1'b1, 1'b0);
    n_checks++; if (count !== 4'd8 || overflow !== 1'b0) begin n_fail++; $display("FAIL full_wr_rd: got count %0d ovf %b want 8/0", count, overflow); end
    n_checks++; if (evt !== 10'h021) begin n_fail++; $display("FAIL full_wr_rd_head: got %h want 021", evt); end
    for (int i = 0; i < 7; i++) pop();
    n_checks++; if (count !== 4'd1 || evt !== 10'h030) begin n_fail++; $display("FAIL full_wr_rd_tail: got count %0d evt %h want 1/030", count, evt); end
    clear();
  endtask

  task automatic test_empty_ops();
    pop();
    n_checks++; if (count !== 4'd0 || evt_valid !== 1'b0) begin n_fail++; $display("FAIL empty_pop: got count %0d valid %b want 0/0", count, evt_valid); end
    cyc(1'b1, 8'h3A, 1'b1, 1'b0);
    n_checks++; if (count !== 4'd1 || evt !== 10'h03A) begin n_fail++; $display("FAIL empty_wr_rd: got count %0d evt %h want 1/03a", count, evt); end
    clear();
  endtask

  task automatic test_mods();
    send(8'h12);
    n_checks++; if (mods !== 3'b001) begin n_fail++; $display("FAIL mods_shift: got %b want 001", mods); end
    send(8'h14);
    n_checks++; if (mods !== 3'b011) begin n_fail++; $display("FAIL mods_ctrl: got %b want 011", mods); end
    send(8'hF0); send(8'h12);
    n_checks++; if (mods !== 3'b010) begin n_fail++; $display("FAIL mods_shift_brk: got %b want 010", mods); end
    send(8'hE0); send(8'hF0); send(8'h14);
    n_checks++; if (mods !== 3'b000) begin n_fail++; $display("FAIL mods_ctrl_brk: got %b want 000", mods); end
    send(8'hE0); send(8'h11); send(8'h59);
    n_checks++; if (mods !== 3'b101) begin n_fail++; $display("FAIL mods_alt_shift: got %b want 101", mods); end
    send(8'hE0); send(8'h59);
    n_checks++; if (mods !== 3'b101) begin n_fail++; $display("FAIL mods_fake: got %b want 101", mods); end
    clear();
    n_checks++; if (mods !== 3'b000 || count !== 4'd0) begin n_fail++; $display("FAIL mods_clr: got mods %b count %0d want 000/0", mods, count); end
  endtask

  task automatic test_reset_mid_prefix();
    send(8'h1C);
    send(8'hE0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (count !== 4'd0 || evt_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst: got count %0d valid %b want 0/0", count, evt_valid); end
    @(negedge clk);
    rst = 1'b0;
    send(8'h75);
    n_checks++; if (count !== 4'd1 || evt !== 10'h075) begin n_fail++; $display("FAIL rst_prefix: got count %0d evt %h want 1/075", count, evt); end
    pop();
  endtask

  task automatic test_clr();
    send(8'h1C); send(8'h1D);
    cyc(1'b1, 8'h1E, 1'b1, 1'b1);
    n_checks++; if (count !== 4'd0 || evt_valid !== 1'b0) begin n_fail++; $display("FAIL clr_prio: got count %0d valid %b want 0/0", count, evt_valid); end
    send(8'hE0);
    clear();
    send(8'h75);
    n_checks++; if (evt !== 10'h075) begin n_fail++; $display("FAIL clr_fsm: got evt %h want 075", evt); end
    clear();
  endtask

  initial begin
    test_reset();
    test_make();
    test_ext_break();
    test_pause();
    test_overflow();
    test_full_wr_rd();
    test_empty_ops();
    test_mods();
    test_reset_mid_prefix();
    test_clr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
